// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl: operand sequencer and result collector for add_serial.
// Buffers operand pairs in a FIFO, issues them one at a time to the serial
// adder with a one-cycle en pulse, then captures and offers the sum.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand-pair stream (in_a, in_b)
//   add_a/add_b/add_en    to the adder (operands held for the whole add)
//   add_out               adder result
//   res_valid/res_ready   result stream (res_data)
//   busy                  op in flight or operands buffered
// Optional build macro ADD_SERIAL_CHECK_EN adds chk_err (sticky) and
// chk_cnt (saturating) that flag add_out != add_a + add_b at capture.
module add_serial_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADD_CYCLES = 9,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
`ifdef ADD_SERIAL_CHECK_EN
    ,
    output logic             chk_err,
    output logic [7:0]       chk_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(ADD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] mem_a_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_b_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0] count_q;

    logic [WIDTH-1:0] add_a_q, add_b_q;
    logic [WIDTH-1:0] res_data_q;
    logic res_valid_q;

    logic full, empty, push, pop;
    logic load, capture, res_take;

    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // The head entry stays in the FIFO until its result is captured.
    assign pop      = capture;

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE) || !empty;

    // Operand FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_a_q[wr_ptr_q] <= in_a;
                mem_b_q[wr_ptr_q] <= in_b;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        capture  = 1'b0;
        res_take = 1'b0;
        add_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_en  = 1'b1;
                cnt_d   = CW'(ADD_CYCLES);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_take = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                add_a_q <= mem_a_q[rd_ptr_q];
                add_b_q <= mem_b_q[rd_ptr_q];
            end
            if (capture) begin
                res_data_q  <= add_out;
                res_valid_q <= 1'b1;
            end else if (res_take) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef ADD_SERIAL_CHECK_EN
    logic [WIDTH-1:0] sum_ref;
    logic mismatch;
    logic chk_err_q;
    logic [7:0] chk_cnt_q;

    assign sum_ref  = add_a_q + add_b_q;
    assign mismatch = capture && (add_out != sum_ref);
    assign chk_err  = chk_err_q;
    assign chk_cnt  = chk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
            chk_cnt_q <= '0;
        end else if (mismatch) begin
            chk_err_q <= 1'b1;
            if (chk_cnt_q != 8'hFF) begin
                chk_cnt_q <= chk_cnt_q + 1'b1;
            end
        end
    end
`endif

endmodule
